// File: rtl/pt2262_encoder_param.sv
// PT2262-style tri-state encoder: address trits, data bits and a sync bit in 1:3 pulse-width code.
// The first symbol starts one clock after start is accepted; start is ignored while busy.
module pt2262_encoder_param #(
  parameter int CLK_DIV    = 250,
  parameter int ADDR_TRITS = 8,
  parameter int DATA_BITS  = 4,
  parameter int REPEAT     = 4
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         start,
  input  logic                                         cont,
  input  logic [2*ADDR_TRITS-1:0]                      addr,
  input  logic [((DATA_BITS > 0) ? DATA_BITS : 1)-1:0] data,
  output logic                                         cod_o,
  output logic                                         sync,
  output logic                                         busy,
  output logic                                         done,
  output logic [3:0]                                   word_cnt
);
  localparam int DW   = (DATA_BITS > 0) ? DATA_BITS : 1;
  localparam int NSYM = ADDR_TRITS + DATA_BITS;
  localparam int SW   = $clog2(NSYM) + 1;
  localparam int DIVW = $clog2(CLK_DIV);
  localparam logic [DIVW-1:0] DIV_MAX   = DIVW'(CLK_DIV - 1);
  localparam logic [DIVW-1:0] DIV_ONE   = DIVW'(1);
  localparam logic [SW-1:0]   SYM_ONE   = SW'(1);
  localparam logic [SW-1:0]   FIRST_DAT = SW'(ADDR_TRITS);
  localparam logic [SW-1:0]   LAST_TRIT = SW'(ADDR_TRITS - 1);
  localparam logic [SW-1:0]   LAST_SYM  = SW'(NSYM - 1);

  typedef enum logic [1:0] {IDLE, TRIT, DBIT, SYNC} state_t;
  typedef enum logic [1:0] {K_ZERO, K_ONE, K_FLOAT, K_SYNC} kind_t;

  state_t           state, state_n;
  kind_t            kind;
  logic [1:0]       phase, phase_n;     // 0..3 = H1 L1 H2 L2
  logic [6:0]       alpha_cnt, alpha_n, phase_len;
  logic [SW-1:0]    sym_idx, sym_n;
  logic [DIVW-1:0]  div_cnt, div_n;
  logic [3:0]       word_n, word_inc;
  logic             done_n, load, tick, last_phase, dbit;
  logic [1:0]       trit;
  logic [2*ADDR_TRITS-1:0] addr_q;
  logic [DW-1:0]    data_q;

  always_comb begin
    trit     = 2'(addr_q >> {sym_idx, 1'b0});
    dbit     = 1'(data_q >> (sym_idx - FIRST_DAT));
    tick     = (div_cnt == DIV_MAX);
    word_inc = (word_cnt == 4'hF) ? 4'hF : word_cnt + 4'd1;
    if (state == SYNC)      kind = K_SYNC;
    else if (state == DBIT) kind = dbit ? K_ONE : K_ZERO;
    else if (trit[1])       kind = K_FLOAT;
    else                    kind = trit[0] ? K_ONE : K_ZERO;
    case (kind)
      K_ZERO:  phase_len = phase[0] ? 7'd12 : 7'd4;
      K_ONE:   phase_len = phase[0] ? 7'd4 : 7'd12;
      K_FLOAT: phase_len = (phase == 2'd0 || phase == 2'd3) ? 7'd4 : 7'd12;
      default: phase_len = phase[0] ? 7'd124 : 7'd4;
    endcase
    last_phase = (kind == K_SYNC) ? (phase == 2'd1) : (phase == 2'd3);
  end

  always_comb begin
    state_n = state;
    phase_n = phase;
    alpha_n = alpha_cnt;
    sym_n   = sym_idx;
    div_n   = div_cnt;
    word_n  = word_cnt;
    done_n  = 1'b0;
    load    = 1'b0;
    if (state == IDLE) begin
      if (start) begin
        state_n = TRIT;
        phase_n = 2'd0;
        alpha_n = '0;
        sym_n   = '0;
        div_n   = '0;
        word_n  = 4'd0;
        load    = 1'b1;
      end
    end else begin
      div_n = tick ? '0 : div_cnt + DIV_ONE;
      if (tick) begin
        if (alpha_cnt == phase_len - 7'd1) begin
          alpha_n = '0;
          if (!last_phase) begin
            phase_n = phase + 2'd1;
          end else begin
            phase_n = 2'd0;
            if (state == SYNC) begin
              // word boundary: next word follows immediately or the burst ends
              word_n = word_inc;
              if (cont || (word_inc < 4'(REPEAT))) begin
                state_n = TRIT;
                sym_n   = '0;
                load    = 1'b1;
              end else begin
                state_n = IDLE;
                done_n  = 1'b1;
              end
            end else begin
              sym_n = sym_idx + SYM_ONE;
              if (state == TRIT && sym_idx == LAST_TRIT)
                state_n = (DATA_BITS > 0) ? DBIT : SYNC;
              else if (state == DBIT && sym_idx == LAST_SYM)
                state_n = SYNC;
            end
          end
        end else begin
          alpha_n = alpha_cnt + 7'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      phase     <= 2'd0;
      alpha_cnt <= '0;
      sym_idx   <= '0;
      div_cnt   <= '0;
      word_cnt  <= 4'd0;
      done      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      state     <= state_n;
      phase     <= phase_n;
      alpha_cnt <= alpha_n;
      sym_idx   <= sym_n;
      div_cnt   <= div_n;
      word_cnt  <= word_n;
      done      <= done_n;
      if (load) begin
        addr_q <= addr;
        data_q <= data;
      end
    end
  end

  assign busy  = (state != IDLE);
  assign cod_o = (state != IDLE) && !phase[0];
  assign sync  = (state == SYNC) && (phase == 2'd0);

endmodule

// File: doc/pt2262_encoder_param.md
# pt2262_encoder_param

Parametrised PT2262-compatible tri-state remote-control encoder: serialises a configurable number of address trits (0/1/F) and data bits, then a sync bit, onto `cod_o` using the standard 1:3 pulse-width code. It is the successor to the fixed 8-address/4-data encoder. It adds the following:
- a start/busy/done handshake,
- a programmable repeat count,
- a continuous mode,
- a generic oscillator divider.

It sits between the control logic that supplies address/data and the RF/OOK transmitter driving the antenna.

## Interface
- `CLK_DIV`, 250: clk cycles per α (oscillator period); legal ≥ 2. The default gives α = 1/12 kHz at 3 MHz.
- `ADDR_TRITS`, 8: number of address trits; legal 1..12.
- `DATA_BITS`, 4: number of data bits; legal 0..8.
- `REPEAT`, 4: words sent per `start` in burst mode; legal 1..15.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `start`  in  1  request a transmission; sampled only in IDLE.
- `cont`  in  1  continuous mode; when 1 at a word boundary, another word follows regardless of `REPEAT`.
- `addr`  in  2*ADDR_TRITS  trit i in `addr[2i+1:2i]`: 00 = 0, 01 = 1, 1x = F.
- `data`  in  max(DATA_BITS,1)  data bit j in `data[j]`; ignored if `DATA_BITS` = 0.
- `cod_o`  out  1  serial encoded waveform.
- `sync`  out  1  equals `cod_o` while the sync bit is being sent, else 0.
- `busy`  out  1  high from the cycle after `start` acceptance until `done`.
- `done`  out  1  one-cycle pulse at the end of the last word.
- `word_cnt`  out  4  number of words completed in the current transmission; saturates at 15.

## Operation
- FSM states: IDLE, TRIT, DBIT, SYNC.
- IDLE → TRIT on `start`=1. `addr`/`data` are latched on this edge, the α divider and the α counter are cleared, and `word_cnt` is cleared to 0.
- Symbols are sent in order: trits A0..A(ADDR_TRITS-1), then bits D0..D(DATA_BITS-1), then sync.
- Each symbol has four phases H1 L1 H2 L2, with durations in α:
  - 0: 4/12/4/12.
  - 1: 12/4/12/4.
  - F: 4/12/12/4.
  - sync: 4/124/0/0.
- Data bits use only the 0/1 codes.
- `cod_o` is 1 during H phases and 0 during L phases.
- Word boundary (end of the sync L1 phase): `word_cnt` increments. Then:
  - If `cont`=1 or `word_cnt` (post-increment) < `REPEAT`: `addr`/`data` are re-latched and the FSM goes to TRIT, symbol 0.
  - Otherwise: `done` pulses, `busy` drops, and the FSM goes to IDLE.
- `start` while busy is ignored. `start` and `cont` sampled in the same IDLE cycle are both honoured.
- Trit code 10 and trit code 11 are both F.
- Changing `addr`/`data` mid-word has no effect until the next word boundary.

## Timing
- Reset (async) drives immediately: `cod_o`=0, `sync`=0, `busy`=0, `done`=0, `word_cnt`=0, state IDLE. Divider and counters go to 0.
- Reset applied mid-word aborts the word with no `done` pulse.
- α tick: asserted every `CLK_DIV` clk cycles, counted from the acceptance edge.
- Latency from acceptance:
  - Acceptance edge = cycle 0.
  - `busy`=1 and `cod_o`=1 (H1 of A0) from cycle 1.
  - Each phase lasts exactly n·`CLK_DIV` cycles.
- Word length is (ADDR_TRITS+DATA_BITS)·32α + 128α.
- Symbols are back-to-back with no gap cycles, including across word boundaries.
- `done` is 1 in the single cycle after the final L1 of sync completes. `busy` is 0 from that same cycle. IDLE can accept a new `start` in that cycle.
- Counters: the α phase counter is 7 bits (max 124). The symbol index is wide enough for `ADDR_TRITS`+`DATA_BITS` (max 20). `word_cnt` is 4 bits and saturating.

## Test plan
1. **Single word, mixed codes.** Setup: CLK_DIV=2, ADDR_TRITS=2, DATA_BITS=1, REPEAT=1. Stimulus: `addr`=2'b01 for A0=1 and 2'b10 for A1=F (`addr`=4'b1001), `data`=1, pulse `start`. Required response:
   - `cod_o` run lengths in clk cycles: 24H 8L 24H 8L | 8H 24L 24H 8L | 24H 8L 24H 8L | 8H 248L.
   - `sync`=1 only for the 8H of sync.
   - `done` at cycle 449; `busy` high for cycles 1..448.
2. **Burst repeat.** Same setup with REPEAT=3. Required response: 3 identical words back-to-back, `word_cnt` steps 1→2→3, a single `done` at cycle 1345.
3. **Continuous mode with mid-stream update.** Stimulus: `cont`=1; change `addr` mid-word 1; drop `cont` during word 3. Required response:
   - Word 1 is unchanged by the mid-word `addr` change.
   - Word 2 carries the new address.
   - Transmission stops after word 3 ends, with `done` pulsing once.
4. **Busy handling.** Stimulus: pulse `start` while `busy`=1. Required response: no restart, no change to the waveform.
5. **Reset mid-symbol.** Stimulus: assert `reset` mid-symbol during an H phase. Required response:
   - `cod_o`, `busy` and `sync` are 0 asynchronously in the same time step.
   - No `done` pulse.
   - A `start` after `reset` is released produces a fresh word from A0.
6. **No data bits.** Setup: DATA_BITS=0, ADDR_TRITS=12, CLK_DIV=2. Stimulus: pulse `start` with all trits = 0. Required response: twelve symbols of 8H 24L 8H 24L, then sync; word length 1024 cycles.
